uart_rx_fifo: RTL and testbench

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

---
 rtl/uart_rx_fifo.sv | 137 +++++++++++++
 tb/tb_uart_rx_fifo.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: UART receiver feeding a first-word fall-through FIFO with sticky error flags.
// Define UART_RX_PARITY_EN to add a parity bit (sense chosen by PARITY_ODD) after the data bits.
module uart_rx_fifo #(
   parameter int CLKS_PER_BIT = 1000,
   parameter int DATA_BITS    = 8,
   parameter int DEPTH        = 16,
   parameter int PARITY_ODD   = 0
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       rx,
   input  logic                       re,
   input  logic                       clr,
   output logic [DATA_BITS-1:0]       dout,
   output logic                       empty,
   output logic                       full,
   output logic [$clog2(DEPTH+1)-1:0] level,
   output logic                       frame_err,
   output logic                       overrun,
   output logic                       parity_err
);
   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam int AW = $clog2(DEPTH);
   localparam int LW = $clog2(DEPTH+1);
   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] START  = 3'd1;
   localparam logic [2:0] DATA   = 3'd2;
   localparam logic [2:0] STOP   = 3'd4;
`ifdef UART_RX_PARITY_EN
   localparam logic [2:0] PARITY = 3'd3;
   localparam logic [2:0] AFTER_DATA = PARITY;
`else
   localparam logic [2:0] AFTER_DATA = STOP;
`endif
   logic                 rx_m, rx_s;
   logic [2:0]           state;
   logic [CW-1:0]        cnt;
   logic [3:0]           idx;
   logic [DATA_BITS-1:0] shreg;
   logic [DATA_BITS-1:0] mem [DEPTH];
   logic [AW-1:0]        wp, rp;
   logic [LW-1:0]        count;
   logic                 mid, bit_end, accept, push, pop, ferr_set, ovr_set, par_bad;
   assign mid      = cnt == CW'((CLKS_PER_BIT-1)/2);
   assign bit_end  = cnt == CW'(CLKS_PER_BIT-1);
   assign accept   = state == STOP && bit_end && rx_s && !par_bad;
   assign ferr_set = state == STOP && bit_end && !rx_s;
   assign pop      = re && !empty;
   assign push     = accept && (!full || re);
   assign ovr_set  = accept && full && !re;
   assign empty    = count == '0;
   assign full     = count == LW'(DEPTH);
   assign level    = count;
   assign dout     = empty ? '0 : mem[rp];
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_m <= 1'b1;
         rx_s <= 1'b1;
      end else begin
         rx_m <= rx;
         rx_s <= rx_m;
      end
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         cnt   <= '0;
         idx   <= '0;
         shreg <= '0;
      end else begin
         case (state)
            IDLE: begin
               cnt <= '0;
               idx <= '0;
               if (!rx_s) state <= START;
            end
            START: begin
               cnt <= mid ? '0 : cnt + CW'(1);
               if (mid) state <= rx_s ? IDLE : DATA;
            end
            DATA: begin
               cnt <= bit_end ? '0 : cnt + CW'(1);
               if (bit_end) begin
                  shreg <= {rx_s, shreg[DATA_BITS-1:1]};
                  idx   <= idx + 4'd1;
                  if (idx == 4'(DATA_BITS-1)) state <= AFTER_DATA;
               end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
               cnt <= bit_end ? '0 : cnt + CW'(1);
               if (bit_end) state <= STOP;
            end
`endif
            STOP: begin
               cnt <= cnt + CW'(1);
               if (bit_end) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
`ifdef UART_RX_PARITY_EN
   logic perr_set;
   assign perr_set = state == PARITY && bit_end && ((^shreg ^ rx_s) != PARITY_ODD[0]);
   // par_bad remembers a parity miss so the following stop sample discards the frame
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         par_bad    <= 1'b0;
         parity_err <= 1'b0;
      end else begin
         par_bad    <= state == IDLE ? 1'b0 : par_bad || perr_set;
         parity_err <= (parity_err && !clr) || perr_set;
      end
   end
`else
   assign par_bad    = 1'b0;
   assign parity_err = 1'b0;
`endif
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wp        <= '0;
         rp        <= '0;
         count     <= '0;
         frame_err <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         wp        <= push ? wp + AW'(1) : wp;
         rp        <= pop ? rp + AW'(1) : rp;
         count     <= count + LW'(push) - LW'(pop);
         frame_err <= (frame_err && !clr) || ferr_set;
         overrun   <= (overrun && !clr) || ovr_set;
      end
   end
   always_ff @(posedge clk)
      if (push) mem[wp] <= shreg;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed frames into uart_rx_fifo; a monitor checks every pop against a queue of expected bytes.
module tb_uart_rx_fifo;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       rx = 1'b1;
   logic       re = 1'b0;
   logic       clr = 1'b0;
   logic [7:0] dout;
   logic       empty, full, frame_err, overrun, parity_err;
   logic [2:0] level;
   logic [7:0] exp_q[$];
   int         passed = 0;
   int         total = 0;
   logic       e_pre, e_post;

   uart_rx_fifo #(.CLKS_PER_BIT(16), .DATA_BITS(8), .DEPTH(4), .PARITY_ODD(0)) dut (
      .clk(clk), .rst_n(rst_n), .rx(rx), .re(re), .clr(clr), .dout(dout), .empty(empty),
      .full(full), .level(level), .frame_err(frame_err), .overrun(overrun), .parity_err(parity_err)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (re && !empty) begin
         total++;
         if (exp_q.size() == 0)
            $display("FAIL pop_data: got %02h but no entry was expected", dout);
         else begin
            logic [7:0] e;
            e = exp_q.pop_front();
            if (dout === e) passed++;
            else $display("FAIL pop_data: got %02h expected %02h", dout, e);
         end
      end
   end

   task automatic chk(input string n, input int a, input int e);
      total++;
      if (a == e) passed++;
      else $display("FAIL %s: got %0h expected %0h", n, a, e);
   endtask

   task automatic rd();
      @(posedge clk); #1 re = 1'b1;
      @(posedge clk); #1 re = 1'b0;
   endtask

   task automatic pulse_clr();
      @(posedge clk); #1 clr = 1'b1;
      @(posedge clk); #1 clr = 1'b0;
   endtask

   // The stop sample lands on edge sc of the frame; strobes are held for the cycle before it.
   task automatic send(input logic [7:0] d, input bit stop_bit, input bit use_par, input bit par,
                       input bit re_p, input bit clr_p);
      logic [10:0] bits;
      int nb, sc;
      bits = '1;
      bits[0] = 1'b0;
      bits[8:1] = d;
      if (use_par) bits[9] = par;
      bits[9 + int'(use_par)] = stop_bit;
      nb = 10 + int'(use_par);
      sc = 155 + 16 * int'(use_par);
      for (int c = 0; c < nb * 16; c++) begin
         @(posedge clk); #1;
         rx  = bits[c / 16];
         re  = re_p && c == sc - 1;
         clr = clr_p && c == sc - 1;
         if (c == sc - 1) e_pre = empty;
         if (c == sc) e_post = empty;
      end
      @(posedge clk); #1 rx = 1'b1;
      repeat (20) @(posedge clk);
      #1;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "timeout");
   end

   initial begin
      repeat (3) @(posedge clk);
      #2;
      chk("rst_empty", empty, 1);
      chk("rst_full", full, 0);
      chk("rst_level", level, 0);
      chk("rst_dout", dout, 0);
      chk("rst_frame_err", frame_err, 0);
      chk("rst_overrun", overrun, 0);
      chk("rst_parity_err", parity_err, 0);
      @(posedge clk); #1 rst_n = 1'b1;
      repeat (5) @(posedge clk);
      #1;

      exp_q.push_back(8'hA5);
      send(8'hA5, 1, 0, 0, 0, 0);
      chk("a5_empty_before_stop", e_pre, 1);
      chk("a5_visible_after_stop", e_post, 0);
      chk("a5_level", level, 1);
      rd();
      chk("a5_empty_after_read", empty, 1);
      chk("a5_level_after_read", level, 0);

      @(posedge clk); #1 rx = 1'b0;
      repeat (4) @(posedge clk);
      #1 rx = 1'b1;
      repeat (200) @(posedge clk);
      #1;
      chk("glitch_empty", empty, 1);
      chk("glitch_frame_err", frame_err, 0);
      chk("glitch_overrun", overrun, 0);

      send(8'h3C, 0, 0, 0, 0, 0);
      chk("ferr_set", frame_err, 1);
      chk("ferr_level", level, 0);
      pulse_clr();
      chk("ferr_clr", frame_err, 0);
      send(8'h3C, 0, 0, 0, 0, 1);
      chk("ferr_clr_same_cycle", frame_err, 1);
      pulse_clr();
      chk("ferr_clr2", frame_err, 0);

      for (int i = 1; i <= 4; i++) begin
         exp_q.push_back(8'(i));
         send(8'(i), 1, 0, 0, 0, 0);
      end
      chk("fill_full", full, 1);
      chk("fill_level", level, 4);
      chk("fill_no_overrun", overrun, 0);
      send(8'h05, 1, 0, 0, 0, 0);
      chk("ovr_set", overrun, 1);
      chk("ovr_level", level, 4);
      repeat (4) rd();
      chk("ovr_drained", empty, 1);
      rd();
      chk("pop_when_empty_level", level, 0);
      pulse_clr();
      chk("ovr_clr", overrun, 0);

      for (int i = 0; i < 4; i++) begin
         exp_q.push_back(8'h11 + 8'(i));
         send(8'h11 + 8'(i), 1, 0, 0, 0, 0);
      end
      exp_q.push_back(8'h06);
      send(8'h06, 1, 0, 0, 1, 0);
      chk("pushpop_overrun", overrun, 0);
      chk("pushpop_level", level, 4);
      repeat (4) rd();
      chk("pushpop_drained", level, 0);

`ifdef UART_RX_PARITY_EN
      send(8'h07, 1, 1, 0, 0, 0);
      chk("par_bad_flag", parity_err, 1);
      chk("par_bad_level", level, 0);
      pulse_clr();
      chk("par_clr", parity_err, 0);
      exp_q.push_back(8'h07);
      send(8'h07, 1, 1, 1, 0, 0);
      chk("par_ok_flag", parity_err, 0);
      chk("par_ok_level", level, 1);
      rd();
`endif

      exp_q.push_back(8'h5A);
      send(8'h5A, 1, 0, 0, 0, 0);
      send(8'hC3, 0, 0, 0, 0, 0);
      chk("pre_rst_level", level, 1);
      chk("pre_rst_frame_err", frame_err, 1);
      @(posedge clk); #1 rx = 1'b0;
      repeat (16) @(posedge clk);
      #1 rx = 1'b1;
      repeat (40) @(posedge clk);
      #1 rst_n = 1'b0;
      exp_q.delete();
      #2;
      chk("midrst_empty", empty, 1);
      chk("midrst_level", level, 0);
      chk("midrst_dout", dout, 0);
      chk("midrst_full", full, 0);
      chk("midrst_frame_err", frame_err, 0);
      @(posedge clk); #1 rst_n = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      chk("post_rst_empty", empty, 1);
      exp_q.push_back(8'h96);
`ifdef UART_RX_PARITY_EN
      send(8'h96, 1, 1, 0, 0, 0);
`else
      send(8'h96, 1, 0, 0, 0, 0);
`endif
      chk("post_rst_level", level, 1);
      rd();
      chk("scoreboard_drained", exp_q.size(), 0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
